// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - memory fetch, decode hand-off and fault signals of the fetch unit
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [6:0]  Opcode;
    logic [31:0] pc_out;
    logic        stall;
    logic        redirect;
    logic [31:0] ImmExt;
    logic        fault;
    logic [1:0]  fault_code;
    logic [31:0] fault_pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output instr_valid, instruction, Opcode, pc_out,
        input  stall, redirect, ImmExt,
        output fault, fault_code, fault_pc
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  instr_valid, instruction, Opcode, pc_out,
        output stall, redirect, ImmExt,
        input  fault, fault_code, fault_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner: fetches one word at a time, holds it for decode, takes branch redirects
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    instr_fetch_unit_if.master  bus
);
    localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);
    localparam logic [31:0]   NOP      = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, REQ, HOLD, FAULT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   instr_q, instr_d;
    logic [31:0]   pc_q, pc_d;
    logic          fault_q, fault_d;
    logic [1:0]    fault_code_q, fault_code_d;
    logic [31:0]   fault_pc_q, fault_pc_d;
    logic [31:0]   target;

    assign target = pc_q + bus.ImmExt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            fetch_pc_q   <= RESET_PC;
            instr_q      <= NOP;
            pc_q         <= RESET_PC;
            fault_q      <= 1'b0;
            fault_code_q <= 2'b00;
            fault_pc_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fetch_pc_q   <= fetch_pc_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
            fault_pc_q   <= fault_pc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        fetch_pc_d   = fetch_pc_q;
        instr_d      = instr_q;
        pc_d         = pc_q;
        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        fault_pc_d   = fault_pc_q;
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                state_d = REQ;
            end
            REQ: begin
                cnt_d = cnt_q + CW'(1);
                // an ack on the last allowed cycle still counts as a hit
                if (bus.imem_ack) begin
                    instr_d = bus.imem_rdata;
                    pc_d    = fetch_pc_q;
                    cnt_d   = '0;
                    state_d = HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    fault_d      = 1'b1;
                    fault_code_d = 2'b01;
                    fault_pc_d   = fetch_pc_q;
                    state_d      = FAULT;
                end
            end
            HOLD: begin
                if (!bus.stall) begin
                    if (!bus.redirect) begin
                        fetch_pc_d = pc_q + 32'd4;
                        state_d    = REQ;
                    end else if (target[1:0] == 2'b00) begin
                        fetch_pc_d = target;
                        state_d    = REQ;
                    end else begin
                        fault_d      = 1'b1;
                        fault_code_d = 2'b10;
                        fault_pc_d   = target;
                        state_d      = FAULT;
                    end
                end
            end
            FAULT: state_d = FAULT;
            default: state_d = IDLE;
        endcase
    end

    assign bus.imem_req    = (state_q == REQ);
    assign bus.imem_addr   = fetch_pc_q;
    assign bus.instr_valid = (state_q == HOLD);
    assign bus.instruction = instr_q;
    assign bus.Opcode      = instr_q[6:0];
    assign bus.pc_out      = pc_q;
    assign bus.fault       = fault_q;
    assign bus.fault_code  = fault_code_q;
    assign bus.fault_pc    = fault_pc_q;
endmodule
